pc_seq_ctrl: RTL and testbench

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

---
 rtl/pc_ctrl_pkg.sv | 28 ++
 rtl/redirect_sel.sv | 50 +++++
 rtl/pc_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC sequencing controller: FSM state encoding,
// redirect-source priority codes and the word-alignment helper.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_WAIT_MEM = 2'd2,
        ST_HALT     = 2'd3
    } pc_state_e;

    // Numeric value doubles as priority: a larger code wins arbitration.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_TRAP = 2'd3
    } redir_src_e;

    localparam int          CNT_W   = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Clear the byte-offset bits so every issued PC is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/redirect_sel.sv
// Redirect arbiter: picks trap > branch > jump among live requests, lets a
// parked (pending) redirect win only when it strictly outranks the live
// winner, and reports the aligned target plus a misalignment flag.
module redirect_sel
    import pc_ctrl_pkg::*;
(
    input  logic        i_trap_req,
    input  logic [31:0] i_trap_vec,
    input  logic        i_br_req,
    input  logic [31:0] i_br_target,
    input  logic        i_jmp_req,
    input  logic [31:0] i_jmp_target,
    input  logic [1:0]  i_pend_src,
    input  logic [31:0] i_pend_target,
    output logic [1:0]  o_src,
    output logic [31:0] o_raw,
    output logic [31:0] o_target,
    output logic        o_misalign
);

    logic [1:0]  w_live_src;
    logic [31:0] w_live_tgt;

    // Fixed-priority pick among live requests, then merge with the pending slot.
    always_comb begin
        w_live_src = SRC_NONE;
        w_live_tgt = '0;
        if (i_trap_req) begin
            w_live_src = SRC_TRAP;
            w_live_tgt = i_trap_vec;
        end else if (i_br_req) begin
            w_live_src = SRC_BR;
            w_live_tgt = i_br_target;
        end else if (i_jmp_req) begin
            w_live_src = SRC_JMP;
            w_live_tgt = i_jmp_target;
        end

        o_src = w_live_src;
        o_raw = w_live_tgt;
        if (i_pend_src > w_live_src) begin
            o_src = i_pend_src;
            o_raw = i_pend_target;
        end
    end

    assign o_target   = align_word(o_raw);
    assign o_misalign = (o_src != SRC_NONE) && (o_raw[1:0] != 2'b00);

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencing controller: boot hold, redirect issue with flush strobes,
// parking of redirects while instruction memory is busy, halt/resume and a
// saturating count of issued redirects.
module pc_seq_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int BOOT_HOLD = 4
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_req,
    input  logic [31:0] trap_vec,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        jmp_req,
    input  logic [31:0] jmp_target,
    input  logic        hazard_stall,
    input  logic        imem_ready,
    input  logic        halt_req,
    input  logic        resume,
    output logic        j_signal,
    output logic [31:0] jump,
    output logic        stall,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        halted,
    output logic        align_err,
    output logic [15:0] redirect_cnt
);

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_HOLD);

    pc_state_e   r_state;
    pc_state_e   w_next;
    logic [3:0]  r_boot_cnt;
    logic [1:0]  r_pend_src;
    logic [31:0] r_pend_tgt;
    logic [15:0] r_redir_cnt;

    logic        w_trap_g;
    logic        w_br_g;
    logic        w_jmp_g;
    logic [1:0]  w_sel_src;
    logic [31:0] w_sel_raw;
    logic [31:0] w_sel_target;
    logic        w_sel_misalign;
    logic        w_sel_valid;
    logic        w_issue;
    logic        w_latch;

    // Requests are invisible in BOOT; HALT only listens to traps.
    assign w_trap_g = trap_req && (r_state != ST_BOOT);
    assign w_br_g   = br_req  && ((r_state == ST_RUN) || (r_state == ST_WAIT_MEM));
    assign w_jmp_g  = jmp_req && ((r_state == ST_RUN) || (r_state == ST_WAIT_MEM));

    redirect_sel u_redirect_sel (
        .i_trap_req    (w_trap_g),
        .i_trap_vec    (trap_vec),
        .i_br_req      (w_br_g),
        .i_br_target   (br_target),
        .i_jmp_req     (w_jmp_g),
        .i_jmp_target  (jmp_target),
        .i_pend_src    (r_pend_src),
        .i_pend_target (r_pend_tgt),
        .o_src         (w_sel_src),
        .o_raw         (w_sel_raw),
        .o_target      (w_sel_target),
        .o_misalign    (w_sel_misalign)
    );

    assign w_sel_valid  = (w_sel_src != SRC_NONE);
    assign redirect_cnt = r_redir_cnt;

    // Next-state and output decode; outputs follow inputs in the same cycle.
    always_comb begin
        w_next      = r_state;
        stall       = 1'b1;
        j_signal    = 1'b0;
        jump        = '0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        halted      = 1'b0;
        align_err   = 1'b0;
        w_issue     = 1'b0;
        w_latch     = 1'b0;

        case (r_state)
            ST_BOOT: begin
                if (r_boot_cnt <= 4'd1) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (imem_ready) begin
                    if (w_sel_valid) w_issue = 1'b1;
                    else             stall   = hazard_stall;
                    w_next = halt_req ? ST_HALT : ST_RUN;
                end else begin
                    // Memory busy: park the winner and retry from WAIT_MEM.
                    w_latch = w_sel_valid;
                    w_next  = (!w_sel_valid && halt_req) ? ST_HALT : ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                if (imem_ready) begin
                    if (w_sel_valid) w_issue = 1'b1;
                    else             stall   = hazard_stall;
                    w_next = halt_req ? ST_HALT : ST_RUN;
                end else begin
                    w_latch = w_sel_valid;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                if (w_sel_valid && imem_ready) begin
                    w_issue = 1'b1;
                    w_next  = ST_RUN;
                end else if (resume && !trap_req) begin
                    // A trap still waiting for memory keeps us here.
                    w_next = ST_RUN;
                end
            end
            default: w_next = ST_BOOT;
        endcase

        if (w_issue) begin
            j_signal    = 1'b1;
            jump        = w_sel_target;
            stall       = 1'b0;
            flush_if_id = 1'b1;
            flush_id_ex = (w_sel_src == SRC_TRAP) || (w_sel_src == SRC_BR);
            align_err   = w_sel_misalign;
        end
    end

    // State, boot counter, pending slot and redirect counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_BOOT;
            r_boot_cnt  <= BOOT_INIT;
            r_pend_src  <= SRC_NONE;
            r_pend_tgt  <= '0;
            r_redir_cnt <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_BOOT) && (r_boot_cnt > 4'd1))
                r_boot_cnt <= r_boot_cnt - 4'd1;
            if (w_issue) begin
                r_pend_src <= SRC_NONE;
                r_pend_tgt <= '0;
            end else if (w_latch) begin
                r_pend_src <= w_sel_src;
                r_pend_tgt <= w_sel_raw;
            end
            if (w_issue && (r_redir_cnt != CNT_MAX))
                r_redir_cnt <= r_redir_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the controller rules.
module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trap_req = 1'b0;
    logic [31:0] trap_vec = '0;
    logic        br_req = 1'b0;
    logic [31:0] br_target = '0;
    logic        jmp_req = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        hazard_stall = 1'b0;
    logic        imem_ready = 1'b1;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        j_signal;
    logic [31:0] jump;
    logic        stall;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        halted;
    logic        align_err;
    logic [15:0] redirect_cnt;

    int total = 0;
    int bad   = 0;

    pc_seq_ctrl #(.BOOT_HOLD(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trap_req     (trap_req),
        .trap_vec     (trap_vec),
        .br_req       (br_req),
        .br_target    (br_target),
        .jmp_req      (jmp_req),
        .jmp_target   (jmp_target),
        .hazard_stall (hazard_stall),
        .imem_ready   (imem_ready),
        .halt_req     (halt_req),
        .resume       (resume),
        .j_signal     (j_signal),
        .jump         (jump),
        .stall        (stall),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .halted       (halted),
        .align_err    (align_err),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    logic [53:0] obs;
    assign obs = {j_signal, jump, stall, flush_if_id, flush_id_ex, halted, align_err, redirect_cnt};

    // Reference model: mode 0=boot, 1=run, 2=waiting for memory, 3=halted.
    int          m_mode, m_boot_left, m_pend_pri, m_cnt;
    logic [31:0] m_pend_tgt;
    int          n_mode, n_boot_left, n_pend_pri, n_cnt;
    logic [31:0] n_pend_tgt;

    task automatic model_reset();
        m_mode = 0; m_boot_left = 4; m_pend_pri = 0; m_pend_tgt = '0; m_cnt = 0;
    endtask

    task automatic model_predict(output logic [53:0] e);
        int lp, cp;
        logic [31:0] lt, ct;
        logic iss, st;
        lp = 0; lt = '0;
        if (m_mode != 0) begin
            if (trap_req)                     begin lp = 3; lt = trap_vec;   end
            else if (m_mode != 3 && br_req)   begin lp = 2; lt = br_target;  end
            else if (m_mode != 3 && jmp_req)  begin lp = 1; lt = jmp_target; end
        end
        cp = lp; ct = lt;
        if (m_mode == 2 && m_pend_pri > lp) begin cp = m_pend_pri; ct = m_pend_tgt; end
        iss = (m_mode != 0) && imem_ready && (cp > 0);
        if (iss) st = 1'b0;
        else if ((m_mode == 1 || m_mode == 2) && imem_ready) st = hazard_stall;
        else st = 1'b1;
        e = {iss, (iss ? (ct & 32'hFFFF_FFFC) : 32'h0), st, iss, (iss && cp >= 2),
             (m_mode == 3), (iss && (ct % 4 != 0)), 16'(m_cnt)};

        n_mode = m_mode; n_boot_left = m_boot_left; n_pend_pri = m_pend_pri;
        n_pend_tgt = m_pend_tgt; n_cnt = m_cnt;
        if (iss) n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        if (iss) begin n_pend_pri = 0; n_pend_tgt = '0; end
        else if ((m_mode == 1 || m_mode == 2) && !imem_ready && cp > 0) begin
            n_pend_pri = cp; n_pend_tgt = ct;
        end
        case (m_mode)
            0: if (m_boot_left == 1) n_mode = 1; else n_boot_left = m_boot_left - 1;
            1: if (imem_ready) n_mode = halt_req ? 3 : 1;
               else n_mode = (cp == 0 && halt_req) ? 3 : 2;
            2: if (imem_ready) n_mode = halt_req ? 3 : 1;
            default: if (iss || (resume && !trap_req)) n_mode = 1;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        m_mode = n_mode; m_boot_left = n_boot_left; m_pend_pri = n_pend_pri;
        m_pend_tgt = n_pend_tgt; m_cnt = n_cnt;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        trap_req = 0; br_req = 0; jmp_req = 0; halt_req = 0; resume = 0;
        hazard_stall = 0; imem_ready = 1;
    endtask

    task automatic assert_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        assert_reset();
        #1;
        total++;
        if (obs !== {1'b0, 32'h0, 1'b1, 4'b0000, 16'h0000})
            begin bad++; $display("FAIL reset_outputs got=%h exp=%h", obs, {1'b0, 32'h0, 1'b1, 4'b0000, 16'h0000}); end
        // Requests during reset must not leak out.
        br_req = 1; br_target = 32'h55; trap_req = 1; trap_vec = 32'h66;
        #2;
        total++;
        if ({j_signal, jump, stall, flush_if_id, flush_id_ex, align_err} !== {1'b0, 32'h0, 1'b1, 3'b000})
            begin bad++; $display("FAIL reset_ignores_req got j=%b jump=%h stall=%b", j_signal, jump, stall); end
        idle_inputs();
        release_reset();
    endtask

    task automatic test_boot();
        logic [53:0] e;
        int run_len;
        bit seen_low;
        run_len = 0; seen_low = 0;
        br_req = 1; br_target = 32'h700;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) br_req = 0;
            #1;
            model_predict(e);
            total++;
            if (obs !== e) begin bad++; $display("FAIL boot_cycle%0d got=%h exp=%h", i, obs, e); end
            if (i < 3) begin
                total++;
                if ({j_signal, flush_if_id, flush_id_ex, align_err} !== 4'b0000)
                    begin bad++; $display("FAIL boot_quiet got=%b%b%b%b exp=0000", j_signal, flush_if_id, flush_id_ex, align_err); end
            end
            if (!seen_low && stall === 1'b1) run_len++; else seen_low = 1;
            tick();
        end
        total++;
        if (run_len !== 4) begin bad++; $display("FAIL boot_hold_len got=%0d exp=4", run_len); end
    endtask

    task automatic test_priority();
        logic [53:0] e;
        idle_inputs();
        br_req = 1; br_target = 32'h100; jmp_req = 1; jmp_target = 32'h200;
        #1; model_predict(e);
        total++;
        if (obs !== e) begin bad++; $display("FAIL prio_model got=%h exp=%h", obs, e); end
        total++;
        if ({j_signal, jump, flush_if_id, flush_id_ex, stall} !== {1'b1, 32'h100, 1'b1, 1'b1, 1'b0})
            begin bad++; $display("FAIL br_over_jmp got j=%b jump=%h fi=%b fe=%b exp j=1 jump=100 fi=1 fe=1", j_signal, jump, flush_if_id, flush_id_ex); end
        tick();
        idle_inputs();
        jmp_req = 1; jmp_target = 32'h204;
        #1; model_predict(e);
        total++;
        if ({j_signal, jump, flush_if_id, flush_id_ex} !== {1'b1, 32'h204, 1'b1, 1'b0})
            begin bad++; $display("FAIL jmp_flush got j=%b jump=%h fe=%b exp fe=0", j_signal, jump, flush_id_ex); end
        tick();
        idle_inputs();
        trap_req = 1; trap_vec = 32'h800; br_req = 1; br_target = 32'h900;
        #1; model_predict(e);
        total++;
        if ({j_signal, jump, flush_id_ex} !== {1'b1, 32'h800, 1'b1})
            begin bad++; $display("FAIL trap_over_br got jump=%h exp=00000800", jump); end
        tick();
        idle_inputs();
        hazard_stall = 1;
        #1; model_predict(e);
        total++;
        if ({stall, j_signal, redirect_cnt} !== {1'b1, 1'b0, 16'd3})
            begin bad++; $display("FAIL hazard_idle got stall=%b cnt=%0d exp stall=1 cnt=3", stall, redirect_cnt); end
        tick();
        idle_inputs();
    endtask

    task automatic test_wait_mem();
        logic [53:0] e;
        int pulses;
        logic [31:0] seen_jump;
        pulses = 0; seen_jump = '0;
        for (int c = 0; c < 4; c++) begin
            idle_inputs();
            case (c)
                0: begin imem_ready = 0; jmp_req = 1; jmp_target = 32'h40; end
                1: begin imem_ready = 0; trap_req = 1; trap_vec = 32'h80; end
                2: begin imem_ready = 1; end
                default: ;
            endcase
            #1; model_predict(e);
            total++;
            if (obs !== e) begin bad++; $display("FAIL wait_model c%0d got=%h exp=%h", c, obs, e); end
            if (j_signal === 1'b1) begin pulses++; seen_jump = jump; end
            tick();
        end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL wait_pulses got=%0d exp=1", pulses); end
        total++;
        if (seen_jump !== 32'h80) begin bad++; $display("FAIL wait_target got=%h exp=00000080", seen_jump); end
        idle_inputs();
    endtask

    task automatic test_align();
        logic [53:0] e;
        idle_inputs();
        br_req = 1; br_target = 32'h103;
        #1; model_predict(e);
        total++;
        if ({j_signal, jump, align_err} !== {1'b1, 32'h100, 1'b1})
            begin bad++; $display("FAIL align_issue got jump=%h err=%b exp jump=00000100 err=1", jump, align_err); end
        tick();
        idle_inputs();
        #1; model_predict(e);
        total++;
        if (align_err !== 1'b0) begin bad++; $display("FAIL align_pulse got=%b exp=0", align_err); end
        tick();
    endtask

    task automatic test_halt();
        logic [53:0] e;
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            case (c)
                0: halt_req = 1;
                1: begin br_req = 1; br_target = 32'h20; end
                2: resume = 1;
                3: hazard_stall = 1;
                default: ;
            endcase
            #1; model_predict(e);
            total++;
            if (obs !== e) begin bad++; $display("FAIL halt_model c%0d got=%h exp=%h", c, obs, e); end
            case (c)
                1: begin
                    total++;
                    if ({j_signal, halted, stall} !== 3'b011)
                        begin bad++; $display("FAIL halt_ignores_br got j=%b halted=%b stall=%b exp 0 1 1", j_signal, halted, stall); end
                end
                3: begin
                    total++;
                    if ({halted, stall} !== 2'b01)
                        begin bad++; $display("FAIL resume_hazard got halted=%b stall=%b exp 0 1", halted, stall); end
                end
                4: begin
                    total++;
                    if ({halted, stall} !== 2'b00)
                        begin bad++; $display("FAIL resume_run got halted=%b stall=%b exp 0 0", halted, stall); end
                end
                default: ;
            endcase
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [53:0] e;
        for (int i = 0; i < 1500; i++) begin
            trap_req     = ($urandom_range(0, 7) == 0);
            br_req       = ($urandom_range(0, 3) == 0);
            jmp_req      = ($urandom_range(0, 3) == 0);
            trap_vec     = $urandom;
            br_target    = $urandom;
            jmp_target   = $urandom;
            imem_ready   = ($urandom_range(0, 3) != 0);
            hazard_stall = ($urandom_range(0, 3) == 0);
            halt_req     = ($urandom_range(0, 15) == 0);
            resume       = ($urandom_range(0, 3) == 0);
            #1; model_predict(e);
            total++;
            if (obs !== e) begin bad++; $display("FAIL random_cycle%0d got=%h exp=%h", i, obs, e); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_wait();
        logic [53:0] e;
        // Leave halt if random traffic ended there.
        resume = 1;
        #1; model_predict(e); tick();
        idle_inputs();
        imem_ready = 0; br_req = 1; br_target = 32'h300;
        #1; model_predict(e); tick();
        idle_inputs();
        imem_ready = 0;
        #1; model_predict(e);
        total++;
        if (obs !== e) begin bad++; $display("FAIL midwait_model got=%h exp=%h", obs, e); end
        tick();
        assert_reset();
        release_reset();
        for (int c = 0; c < 7; c++) begin
            #1; model_predict(e);
            if (c >= 4) begin
                total++;
                if (j_signal !== 1'b0) begin bad++; $display("FAIL pending_discarded got j=%b jump=%h exp j=0", j_signal, jump); end
            end
            total++;
            if (obs !== e) begin bad++; $display("FAIL midwait_after c%0d got=%h exp=%h", c, obs, e); end
            tick();
        end
    endtask

    task automatic test_saturation();
        logic [53:0] e;
        @(negedge clk);
        assert_reset();
        release_reset();
        for (int c = 0; c < 4; c++) begin #1; model_predict(e); tick(); end
        jmp_req = 1; jmp_target = 32'h4;
        for (int i = 0; i < 65536; i++) begin
            if (i == 65534) begin
                total++;
                if (redirect_cnt !== 16'hFFFE) begin bad++; $display("FAIL cnt_pre_sat got=%h exp=fffe", redirect_cnt); end
            end
            model_predict(e);
            tick();
        end
        #1;
        total++;
        if (redirect_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_sat got=%h exp=ffff", redirect_cnt); end
        model_predict(e);
        total++;
        if (j_signal !== 1'b1) begin bad++; $display("FAIL cnt_extra_issue got j=%b exp=1", j_signal); end
        tick();
        #1;
        total++;
        if (redirect_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_stays got=%h exp=ffff", redirect_cnt); end
        assert_reset();
        #1;
        total++;
        if (redirect_cnt !== 16'h0000) begin bad++; $display("FAIL cnt_reset got=%h exp=0000", redirect_cnt); end
        release_reset();
    endtask

    initial begin
        test_reset();
        test_boot();
        test_priority();
        test_wait_mem();
        test_align();
        test_halt();
        test_random();
        test_reset_mid_wait();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
